// File: rtl/mac_dot_seq_if.sv
// Handshake and multiplier-side bus for the dot-product sequencer.
// master: operand fetch / result consumer / multiplier side; slave: sequencer.
interface mac_dot_seq_if #(
  parameter int MAC_CONF_WIDTH = 2,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_INT_WIDTH  = 40,
  parameter int MAC_ACC_WIDTH  = 48,
  parameter int LEN_WIDTH      = 8
);
  // job request
  logic                        start;
  logic [MAC_CONF_WIDTH-1:0]   cfg_in;
  logic [LEN_WIDTH-1:0]        len_in;
  logic                        busy;
  logic                        err;
  // operand stream
  logic                        op_valid;
  logic                        op_ready;
  logic [4*MAC_MIN_WIDTH-1:0]  op_a;
  logic [MAC_MIN_WIDTH-1:0]    op_b;
  // multiplier drive / product return
  logic [MAC_CONF_WIDTH-1:0]   mul_cfg;
  logic                        mul_en;
  logic [4*MAC_MIN_WIDTH-1:0]  mul_a;
  logic [MAC_MIN_WIDTH-1:0]    mul_b;
  logic [MAC_INT_WIDTH-1:0]    mul_c;
  // result
  logic                        res_valid;
  logic                        res_ready;
  logic [MAC_ACC_WIDTH-1:0]    res_data;

  modport master (
    output start, cfg_in, len_in, op_valid, op_a, op_b, mul_c, res_ready,
    input  busy, err, op_ready, mul_cfg, mul_en, mul_a, mul_b, res_valid, res_data
  );

  modport slave (
    input  start, cfg_in, len_in, op_valid, op_a, op_b, mul_c, res_ready,
    output busy, err, op_ready, mul_cfg, mul_en, mul_a, mul_b, res_valid, res_data
  );
endinterface

// File: rtl/mac_dot_seq.sv
// Dot-product job sequencer around a combinational 4-lane MAC multiplier.
// Accepted beat -> mul_a/mul_b regs -> prod_reg -> accumulator; result
// offered on a valid/ready port once the pipeline has drained.
module mac_dot_seq #(
  parameter int MAC_CONF_WIDTH = 2,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_INT_WIDTH  = 40,
  parameter int MAC_ACC_WIDTH  = 48,
  parameter int LEN_WIDTH      = 8
) (
  input  logic           clk,
  input  logic           rst,
  mac_dot_seq_if.slave   bus
);

  // vld_pipe[0]: operands sit in mul_a/mul_b; vld_pipe[1]: product sits in prod_reg
  localparam int STAGES = 1;
  localparam logic [MAC_CONF_WIDTH-1:0] CFG_ILLEGAL = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                      state;
  logic [LEN_WIDTH-1:0]        remaining;
  logic [STAGES:0]             vld_pipe;
  logic [MAC_CONF_WIDTH-1:0]   mul_cfg_q;
  logic                        busy_q, err_q, mul_en_q, res_valid_q;
  logic [4*MAC_MIN_WIDTH-1:0]  mul_a_q;
  logic [MAC_MIN_WIDTH-1:0]    mul_b_q;
  logic [MAC_INT_WIDTH-1:0]    prod_reg;
  logic [MAC_ACC_WIDTH-1:0]    acc;
  logic [MAC_ACC_WIDTH-1:0]    prod_ext;
  logic                        op_ready_w, accept, start_job;

  assign op_ready_w = (state == RUN) && (remaining != '0);
  assign accept     = bus.op_valid && op_ready_w;
  assign start_job  = (state == IDLE) && bus.start && (bus.cfg_in != CFG_ILLEGAL);

  // quad mode yields a signed product; narrower modes are unsigned
  always_comb begin
    prod_ext = MAC_ACC_WIDTH'(prod_reg);
    if (mul_cfg_q[1]) prod_ext = MAC_ACC_WIDTH'($signed(prod_reg));
  end

  // job control FSM; all control outputs are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      mul_cfg_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      mul_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.cfg_in == CFG_ILLEGAL) begin
            err_q <= 1'b1;
          end else if (start_job) begin
            mul_cfg_q <= bus.cfg_in;
            remaining <= bus.len_in;
            busy_q    <= 1'b1;
            if (bus.len_in == '0) begin
              state       <= DONE;
              res_valid_q <= 1'b1;
            end else begin
              state    <= RUN;
              mul_en_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // stage 1 empty means the last product is being summed on this edge
          if (!vld_pipe[0]) begin
            state       <= DONE;
            mul_en_q    <= 1'b0;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mul_cfg_q   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // operand capture, product register and accumulate pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      prod_reg <= '0;
      acc      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      if (accept) begin
        mul_a_q <= bus.op_a;
        mul_b_q <= bus.op_b;
      end
      if (vld_pipe[0]) prod_reg <= bus.mul_c;
      if (start_job)             acc <= '0;
      else if (vld_pipe[STAGES]) acc <= acc + prod_ext;
    end
  end

  assign bus.op_ready  = op_ready_w;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.mul_cfg   = mul_cfg_q;
  assign bus.mul_en    = mul_en_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = acc;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: behavioural multiplier stub plus a dot-product
// reference computed directly from the beat tables.
module tb_mac_dot_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] beat_a [256];
  logic [7:0]  beat_b [256];

  mac_dot_seq_if bus ();

  mac_dot_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // multiply block: single A3*B3, dual (A3+A2)*B3 unsigned, quad signed sum Ai*B3
  function automatic logic [39:0] mul_stub(input logic en, input logic [1:0] c,
                                           input logic [31:0] a, input logic [7:0] b);
    int p;
    p = 0;
    if (en) begin
      case (c)
        2'b00: p = int'(a[31:24]) * int'(b);
        2'b01: p = (int'(a[31:24]) + int'(a[23:16])) * int'(b);
        2'b10: for (int k = 0; k < 4; k++) p += int'($signed(a[8*k +: 8])) * int'($signed(b));
        default: p = 0;
      endcase
    end
    return 40'(p);
  endfunction

  assign bus.mul_c = mul_stub(bus.mul_en, bus.mul_cfg, bus.mul_a, bus.mul_b);

  // expected job result: plain sum of per-beat products modulo 2^48
  function automatic logic [47:0] ref_dot(input logic [1:0] c, input int n);
    longint s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      case (c)
        2'b00: s += longint'(beat_a[i][31:24]) * longint'(beat_b[i]);
        2'b01: s += (longint'(beat_a[i][31:24]) + longint'(beat_a[i][23:16])) * longint'(beat_b[i]);
        default:
          for (int k = 0; k < 4; k++)
            s += longint'($signed(beat_a[i][8*k +: 8])) * longint'($signed(beat_b[i]));
      endcase
    end
    return s[47:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      beat_a[i] = $urandom;
      beat_b[i] = 8'($urandom);
    end
  endtask

  // drives one job; returns observations for the calling test to judge
  task automatic run_job(input logic [1:0] c, input int n, input int gap, input int hold,
                         output logic [47:0] got, output int lat, output int span,
                         output int ctl_bad, output int stab_bad, output logic [3:0] post,
                         output bit tmo);
    int i, g, w, s, t_last;
    bit acc;
    ctl_bad = 0; stab_bad = 0; tmo = 0; got = '0;
    s = cyc; t_last = cyc;
    bus.start = 1'b1; bus.cfg_in = c; bus.len_in = 8'(n);
    step();
    bus.start = 1'b0;
    i = 0; g = 0; w = 0;
    while (i < n && w < 400) begin
      if (g == 0) begin
        bus.op_valid = 1'b1; bus.op_a = beat_a[i]; bus.op_b = beat_b[i];
      end else begin
        bus.op_valid = 1'b0; bus.op_a = $urandom; bus.op_b = 8'($urandom);
      end
      if (bus.mul_cfg !== c || bus.mul_en !== 1'b1 || bus.busy !== 1'b1) ctl_bad++;
      acc = bus.op_valid && bus.op_ready;
      if (acc) t_last = cyc;
      step(); w++;
      if (acc) begin i++; g = gap; end
      else if (g > 0) g--;
    end
    bus.op_valid = 1'b0;
    while (bus.res_valid !== 1'b1 && w < 400) begin
      if (bus.mul_cfg !== c || bus.mul_en !== 1'b1 || bus.busy !== 1'b1) ctl_bad++;
      step(); w++;
    end
    if (w >= 400) tmo = 1;
    lat  = cyc - t_last;
    span = t_last - s;
    if (bus.mul_en !== 1'b0 || bus.busy !== 1'b1 || bus.mul_cfg !== c) ctl_bad++;
    got = bus.res_data;
    for (int k = 0; k < hold; k++) begin
      step();
      if (bus.res_valid !== 1'b1 || bus.res_data !== got) stab_bad++;
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    post = {bus.busy, bus.res_valid, bus.mul_en, |bus.mul_cfg};
  endtask

  task automatic test_reset();
    tests++;
    if ({bus.busy, bus.err, bus.op_ready, bus.mul_en, bus.res_valid, bus.mul_cfg,
         bus.mul_a, bus.mul_b, bus.res_data} !== 95'd0) begin
      fails++; $display("FAIL reset_outputs got busy=%b err=%b rdy=%b en=%b rv=%b cfg=%b a=%h b=%h d=%h exp all 0",
        bus.busy, bus.err, bus.op_ready, bus.mul_en, bus.res_valid, bus.mul_cfg, bus.mul_a, bus.mul_b, bus.res_data);
    end
    rst = 1'b0;
    step();
    tests++;
    if ({bus.busy, bus.op_ready, bus.res_valid, bus.mul_en} !== 4'b0) begin
      fails++; $display("FAIL reset_idle got busy/rdy/rv/en=%b exp 0000",
        {bus.busy, bus.op_ready, bus.res_valid, bus.mul_en});
    end
  endtask

  task automatic test_single();
    logic [47:0] got; int lat, span, cb, sb; logic [3:0] post; bit tmo;
    for (int i = 0; i < 3; i++) begin beat_a[i] = {8'd2, 24'd0}; beat_b[i] = 8'd3; end
    run_job(2'b00, 3, 0, 0, got, lat, span, cb, sb, post, tmo);
    tests++; if (tmo || got !== 48'd18) begin fails++; $display("FAIL single_sum got=%0d exp=18 tmo=%0d", got, tmo); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL single_latency got=%0d exp=3", lat); end
    tests++; if (cb !== 0) begin fails++; $display("FAIL single_ctl bad_cycles=%0d exp=0", cb); end
    tests++; if (post !== 4'b0) begin fails++; $display("FAIL single_post_handshake got=%b exp=0000", post); end
  endtask

  task automatic test_quad();
    logic [47:0] got; int lat, span, cb, sb; logic [3:0] post; bit tmo;
    beat_a[0] = 32'h0000_0002; beat_b[0] = 8'd3;
    run_job(2'b10, 1, 0, 0, got, lat, span, cb, sb, post, tmo);
    tests++; if (tmo || got !== 48'd6) begin fails++; $display("FAIL quad_sum got=%0d exp=6", got); end
    tests++; if (cb !== 0) begin fails++; $display("FAIL quad_mul_cfg bad_cycles=%0d exp=0", cb); end
  endtask

  task automatic test_dual_gaps();
    logic [47:0] got; int lat, span, cb, sb; logic [3:0] post; bit tmo;
    for (int i = 0; i < 2; i++) begin beat_a[i] = {8'd0, 8'd10, 16'd0}; beat_b[i] = 8'd4; end
    run_job(2'b01, 2, 2, 0, got, lat, span, cb, sb, post, tmo);
    tests++; if (tmo || got !== 48'd80) begin fails++; $display("FAIL dual_gap_sum got=%0d exp=80", got); end
    tests++; if (span !== 4) begin fails++; $display("FAIL dual_gap_span got=%0d exp=4", span); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL dual_gap_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_len_zero();
    logic [47:0] got; int lat, span, cb, sb; logic [3:0] post; bit tmo;
    run_job(2'b00, 0, 0, 5, got, lat, span, cb, sb, post, tmo);
    tests++; if (tmo || got !== 48'd0) begin fails++; $display("FAIL len0_sum got=%0d exp=0", got); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL len0_latency got=%0d exp=1", lat); end
    tests++; if (sb !== 0) begin fails++; $display("FAIL len0_stable unstable_cycles=%0d exp=0", sb); end
    tests++; if (post !== 4'b0) begin fails++; $display("FAIL len0_post_handshake got=%b exp=0000", post); end
  endtask

  task automatic test_err_ignore();
    logic [47:0] exp_sum; int w;
    bus.start = 1'b1; bus.cfg_in = 2'b11; bus.len_in = 8'd5;
    step();
    bus.start = 1'b0;
    tests++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL err_pulse got err=%b busy=%b exp err=1 busy=0", bus.err, bus.busy); end
    step();
    tests++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL err_one_cycle got err=%b busy=%b exp 0 0", bus.err, bus.busy); end
    fill_random(2);
    exp_sum = ref_dot(2'b01, 2);
    bus.start = 1'b1; bus.cfg_in = 2'b01; bus.len_in = 8'd2;
    step();
    bus.cfg_in = 2'b10; bus.len_in = 8'd9;
    for (int i = 0; i < 2; i++) begin
      bus.op_valid = 1'b1; bus.op_a = beat_a[i]; bus.op_b = beat_b[i];
      step();
    end
    bus.start = 1'b0; bus.op_valid = 1'b0;
    w = 0;
    while (bus.res_valid !== 1'b1 && w < 20) begin step(); w++; end
    tests++; if (w >= 20 || bus.res_data !== exp_sum) begin
      fails++; $display("FAIL ignore_start_sum got=%h exp=%h", bus.res_data, exp_sum); end
    tests++; if (bus.mul_cfg !== 2'b01 || bus.op_ready !== 1'b0) begin
      fails++; $display("FAIL ignore_start_cfg got cfg=%b rdy=%b exp cfg=01 rdy=0", bus.mul_cfg, bus.op_ready); end
    bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [47:0] got; int lat, span, cb, sb; logic [3:0] post; bit tmo;
    fill_random(4);
    bus.start = 1'b1; bus.cfg_in = 2'b10; bus.len_in = 8'd4;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.op_valid = 1'b1; bus.op_a = beat_a[i]; bus.op_b = beat_b[i];
      step();
    end
    bus.op_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.busy, bus.err, bus.op_ready, bus.mul_en, bus.res_valid, bus.mul_cfg,
         bus.mul_a, bus.mul_b, bus.res_data} !== 95'd0) begin
      fails++; $display("FAIL midrun_reset got busy=%b rdy=%b en=%b rv=%b cfg=%b a=%h b=%h d=%h exp all 0",
        bus.busy, bus.op_ready, bus.mul_en, bus.res_valid, bus.mul_cfg, bus.mul_a, bus.mul_b, bus.res_data);
    end
    step();
    rst = 1'b0;
    step();
    fill_random(4);
    run_job(2'b10, 4, 0, 1, got, lat, span, cb, sb, post, tmo);
    tests++; if (tmo || got !== ref_dot(2'b10, 4)) begin
      fails++; $display("FAIL post_reset_job got=%h exp=%h", got, ref_dot(2'b10, 4)); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] got; int lat, span, cb, sb; logic [3:0] post; bit tmo;
    fill_random(16);
    run_job(2'b10, 16, 0, 0, got, lat, span, cb, sb, post, tmo);
    tests++; if (tmo || got !== ref_dot(2'b10, 16)) begin
      fails++; $display("FAIL b2b_sum got=%h exp=%h", got, ref_dot(2'b10, 16)); end
    tests++; if (span !== 16) begin fails++; $display("FAIL b2b_throughput span=%0d exp=16", span); end
  endtask

  task automatic test_random();
    logic [47:0] got; int lat, span, cb, sb; logic [3:0] post; bit tmo;
    logic [1:0] c; int n;
    for (int j = 0; j < 8; j++) begin
      c = 2'($urandom_range(0, 2));
      n = $urandom_range(1, 12);
      fill_random(n);
      run_job(c, n, $urandom_range(0, 2), $urandom_range(0, 3), got, lat, span, cb, sb, post, tmo);
      tests++; if (tmo || got !== ref_dot(c, n) || lat !== 3 || sb !== 0) begin
        fails++; $display("FAIL random_job%0d cfg=%0d len=%0d got=%h exp=%h lat=%0d sb=%0d",
          j, c, n, got, ref_dot(c, n), lat, sb); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_in = '0; bus.len_in = '0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_quad();
    test_dual_gaps();
    test_len_zero();
    test_err_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
